// File: rtl/seq_pkg.sv
// seq_pkg: shared types, constants and helpers for the seq_bitgen pattern source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pkg;

    localparam int SEQ_WIDTH = 32;
    localparam int SEQ_PTR_W = 6;

    // Fibonacci feedback taps 32, 22, 2, 1 (bit n-1 set for tap n)
    localparam logic [31:0] SEQ_LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_e;

    // Lengths of 0 or beyond the register width mean "use the whole register"
    function automatic int unsigned seq_coerce_len(int unsigned len, int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/seq_lfsr_step.sv
// seq_lfsr_step: one right-shift step of a Fibonacci LFSR; feedback enters at the MSB.
// Latency: combinational.
// Backpressure: none.
module seq_lfsr_step
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] state_o
);

    logic fb;

    // Parity of the tapped bits becomes the new MSB; bit 0 is the one just emitted
    always_comb begin
        fb      = ^(state_i & WIDTH'(SEQ_LFSR_TAPS));
        state_o = {fb, state_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_bitgen.sv
// seq_bitgen: loadable, length-programmable circular serial pattern source (LSB first).
// Latency: start sampled at edge k gives the first bit with valid after edge k; outputs registered.
// Backpressure: none; stop pauses in place, load while running is dropped and flagged on load_err.
// Optional LFSR emission mode is compiled in with SEQ_BITGEN_LFSR_EN.
module seq_bitgen
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int PTR_W = SEQ_PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] pat_in,
    input  logic [PTR_W-1:0] len_in,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
`ifdef SEQ_BITGEN_LFSR_EN
    input  logic             lfsr_mode,
`endif
    output logic             bit_out,
    output logic             valid,
    output logic             wrap,
    output logic [PTR_W-1:0] ptr,
    output logic             busy,
    output logic             load_err
);

    seq_state_e       state_q;
    logic [WIDTH-1:0] pat_q;
    logic [PTR_W-1:0] len_q;
    logic [PTR_W-1:0] ptr_q;
    logic             oneshot_q;
    logic             bit_q;
    logic             valid_q;
    logic             wrap_q;
    logic             busy_q;
    logic             load_err_q;

    logic             in_run;
    logic             do_load;
    logic             do_start;
    logic             emit_d;
    logic             last_d;
    logic             oneshot_d;
    logic             bit_d;
    logic [WIDTH-1:0] pat_sel_d;
    logic [WIDTH-1:0] pat_emit_d;
    logic [WIDTH-1:0] pat_shift;
    logic [WIDTH-1:0] pat_nxt_d;
    logic [PTR_W-1:0] len_sel_d;
    logic [PTR_W-1:0] ptr_sel_d;
    logic [PTR_W-1:0] ptr_nxt_d;

`ifdef SEQ_BITGEN_LFSR_EN
    logic             lfsr_q;
    logic             lfsr_d;
    logic [WIDTH-1:0] pat_step;
`endif

    // Resolve this cycle's effective pattern/length/pointer (a load lands before a same-cycle start)
    always_comb begin
        in_run    = (state_q == ST_RUN);
        do_load   = load && !in_run;
        do_start  = start && !stop && !in_run;
        emit_d    = in_run ? !stop : do_start;
        pat_sel_d = do_load ? pat_in : pat_q;
        len_sel_d = do_load ? PTR_W'(seq_coerce_len(32'(len_in), WIDTH)) : len_q;
        ptr_sel_d = do_load ? '0 : ptr_q;
        oneshot_d = do_start ? oneshot : oneshot_q;
        last_d    = (ptr_sel_d == len_sel_d - PTR_W'(1));
        ptr_nxt_d = last_d ? '0 : ptr_sel_d + PTR_W'(1);
`ifdef SEQ_BITGEN_LFSR_EN
        lfsr_d     = do_start ? lfsr_mode : lfsr_q;
        // An all-zero seed would lock the LFSR at zero forever
        pat_emit_d = (do_start && lfsr_mode && (pat_sel_d == '0)) ? WIDTH'(1) : pat_sel_d;
        pat_shift  = pat_emit_d >> ptr_sel_d;
        bit_d      = lfsr_d ? pat_emit_d[0] : pat_shift[0];
`else
        pat_emit_d = pat_sel_d;
        pat_shift  = pat_emit_d >> ptr_sel_d;
        bit_d      = pat_shift[0];
`endif
    end

`ifdef SEQ_BITGEN_LFSR_EN
    seq_lfsr_step #(.WIDTH(WIDTH)) u_lfsr_step (
        .state_i (pat_emit_d),
        .state_o (pat_step)
    );

    assign pat_nxt_d = (emit_d && lfsr_d) ? pat_step : pat_emit_d;
`else
    assign pat_nxt_d = pat_emit_d;
`endif

    // Control FSM plus all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pat_q      <= '0;
            len_q      <= PTR_W'(WIDTH);
            ptr_q      <= '0;
            oneshot_q  <= 1'b0;
            bit_q      <= 1'b0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            busy_q     <= 1'b0;
            load_err_q <= 1'b0;
`ifdef SEQ_BITGEN_LFSR_EN
            lfsr_q     <= 1'b0;
`endif
        end else begin
            load_err_q <= load && in_run;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            pat_q      <= pat_nxt_d;
            len_q      <= len_sel_d;
            ptr_q      <= ptr_sel_d;
            if (emit_d) begin
                bit_q     <= bit_d;
                valid_q   <= 1'b1;
                wrap_q    <= last_d;
                ptr_q     <= ptr_nxt_d;
                oneshot_q <= oneshot_d;
`ifdef SEQ_BITGEN_LFSR_EN
                lfsr_q    <= lfsr_d;
`endif
                if (last_d && oneshot_d) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b1;
                end
            end else if (in_run) begin
                // Only a stop keeps RUN from emitting; bit_out keeps its last value
                state_q <= ST_HOLD;
                busy_q  <= 1'b0;
            end
        end
    end

    assign bit_out  = bit_q;
    assign valid    = valid_q;
    assign wrap     = wrap_q;
    assign ptr      = ptr_q;
    assign busy     = busy_q;
    assign load_err = load_err_q;

endmodule

// File: doc/seq_bitgen.md
# seq_bitgen

Serial test-pattern source that sits directly upstream of the `seq` sequence detector and drives its `din` input, one bit per `clk`. It replaces ad-hoc bench stimulus with a loadable, length-programmable circular pattern that can be started, paused, resumed and run once or continuously. Its wrap and position outputs let the detector's `dout` be correlated with pattern position.

## Interface
- `WIDTH`, 32, pattern register width; also the maximum pattern length.
- `PTR_W`, 6, width of the pointer and length fields; must satisfy 2^PTR_W > WIDTH.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `load`  in  1  load request; `pat_in` and `len_in` are sampled on the same cycle.
- `pat_in`  in  WIDTH  pattern; bit 0 is emitted first.
- `len_in`  in  PTR_W  pattern length, 1..WIDTH; 0 and values above WIDTH are coerced to WIDTH.
- `start`  in  1  begin or resume emission.
- `stop`  in  1  pause emission.
- `oneshot`  in  1  sampled with `start`; 1 = emit one full pass, then go to IDLE.
- `bit_out`  out  1  serial bit; connects to the detector's `din`.
- `valid`  out  1  `bit_out` carries a new pattern bit this cycle.
- `wrap`  out  1  1-cycle pulse coincident with the last bit of a pass.
- `ptr`  out  PTR_W  index of the next bit to emit.
- `busy`  out  1  state is RUN.
- `load_err`  out  1  1-cycle pulse when `load` is asserted in RUN; that load is ignored.

## Operation
- States:
  - IDLE: reset state.
  - RUN: emitting.
  - HOLD: paused.
- Reset values (asynchronous): pattern 0, length WIDTH, `ptr` 0, state IDLE, `bit_out` 0, `valid` 0, `wrap` 0, `busy` 0, `load_err` 0, oneshot flag 0.
- `load` in IDLE or HOLD:
  - Latches `pat_in` and the coerced `len_in`.
  - Clears `ptr` to 0.
  - State is unchanged.
- `load` in RUN: ignored; `load_err` pulses on the next cycle.
- Priority when inputs coincide: `load` > `stop` > `start`. On a load-with-start in IDLE, the load applies and RUN starts from bit 0 of the new pattern.
- IDLE/HOLD + `start` -> RUN. The oneshot flag is latched from `oneshot`.
- RUN, each cycle:
  - `bit_out` <= pattern[`ptr`], `valid` <= 1.
  - If `ptr` == len-1: `ptr` <= 0 and `wrap` <= 1. Otherwise `ptr` <= `ptr`+1.
- RUN + `stop` -> HOLD.
  - `valid` <= 0 and `bit_out` holds its last value.
  - `ptr` is kept, so a later `start` resumes at the same index.
- RUN with the oneshot flag set: the wrap bit is emitted, then state -> IDLE with `ptr` 0.
- Length 1: every RUN cycle emits pattern[0] with `wrap` high.
- `start` while already in RUN: no effect.

## Timing
- All outputs are registered.
- Latency: `start` sampled at edge k -> `bit_out`=pattern[0] with `valid`=1 after edge k.
- `stop` sampled at edge k -> `valid`=0 after edge k. The bit registered at edge k-1 is the last one emitted.
- Throughput is one bit per cycle in RUN with no bubbles across wrap.
- Reset asserted mid-run clears all state immediately, without waiting for a clock edge.

## Configuration
- `SEQ_BITGEN_LFSR_EN` defined:
  - Adds input `lfsr_mode` (1 bit), sampled with `start`.
  - When the latched value is 1, RUN emits pattern[0] and then shifts the pattern register as a Fibonacci LFSR using the package tap mask.
  - `ptr` and `wrap` still count length as normal.
  - An all-zero seed is replaced by 1 at `start`.
- Not defined: the port is absent, and the pattern register never changes except on `load`.

## Structure
- Package `seq_pkg` holds:
  - the state enum (IDLE, RUN, HOLD);
  - `SEQ_LFSR_TAPS`, default 32'h8020_0003 (taps 32, 22, 2, 1);
  - the length-coercion helper function.
- Sub-module `seq_lfsr_step`: combinational next-state function for the LFSR. It is instantiated only under `SEQ_BITGEN_LFSR_EN`.

## Test plan
- Scenario 1 (continuous run):
  - Stimulus: `rst` pulse, then load `pat_in`=32'hB5, `len_in`=8, `start` with `oneshot`=0.
  - Required: `bit_out` = 1,0,1,0,1,1,0,1 repeating; `wrap` high on every 8th bit; `ptr` cycles 1..7,0.
- Scenario 2 (pause/resume): same run, `stop` after 3 bits, hold 5 cycles, then `start`.
  - During HOLD: `valid`=0 and `ptr`=3.
  - On resume: the next bit is pattern[3]=0.
- Scenario 3 (one-shot and length coercion): `len_in`=0 loads length 32; `oneshot`=1.
  - Required: exactly 32 valid bits, `wrap` on the 32nd, then state IDLE, `busy`=0, `ptr`=0.
- Scenario 4 (load in RUN): assert `load` with `pat_in`=0 while running.
  - Required: `load_err` pulses once; the emitted stream is unchanged.
- Scenario 5 (simultaneous inputs and reset):
  - `stop`+`start` together in RUN -> HOLD.
  - `rst` asserted mid-run -> all outputs 0 before the next edge; `start` after reset emits the zero pattern.
- Scenario 6 (LFSR, with `SEQ_BITGEN_LFSR_EN`): seed 0, `lfsr_mode`=1.
  - Required: the seed becomes 1, the first bit is 1, and the stream matches the reference LFSR model for 100 bits.
